// File: rtl/rf_wport_arb.sv
// Write-port arbiter for the 32x32 register file: shares the single RF write port
// between pipeline writeback (A) and the multi-cycle unit (B), and tracks pending B writes.
module rf_wport_arb #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   input  logic [4:0]  a_wr,
   input  logic [31:0] a_wd,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_wr,
   input  logic [31:0] b_wd,
   output logic        b_ready,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  chk_r1,
   input  logic [4:0]  chk_r2,
   output logic        hazard,
   output logic        rf_we,
   output logic [4:0]  rf_wR,
   output logic [31:0] rf_wD
);

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  r_starve_cnt;
   logic [31:0] r_pending;
   logic        r_clr_vld;
   logic [4:0]  r_clr_idx;
   logic        r_rf_we;
   logic [4:0]  r_rf_wr;
   logic [31:0] r_rf_wd;

   logic        w_force_b;
   logic        w_a_hs;
   logic        w_b_hs;
   logic        w_set_same;
   logic [31:0] w_set_vec;
   logic [31:0] w_clr_vec;
   logic [31:0] w_pending_nxt;

   assign w_force_b = (r_starve_cnt == LP_LIMIT);

   // Arbitration: A has priority unless B has been blocked long enough to be forced through
   always_comb begin
      a_ready = 1'b1;
      b_ready = 1'b0;
      if (w_force_b) begin
         b_ready = 1'b1;
         a_ready = ~b_valid;
      end else begin
         a_ready = 1'b1;
         b_ready = ~a_valid;
      end
   end

   assign w_a_hs     = a_valid & a_ready;
   assign w_b_hs     = b_valid & b_ready;
   assign w_set_same = iss_valid & (iss_rd == b_wr);

   // Scoreboard next state; a B completion clears one cycle late so decode in the
   // following cycle is still covered while the RF write is in flight
   always_comb begin
      w_set_vec = 32'd0;
      w_clr_vec = 32'd0;
      if (iss_valid && (iss_rd != 5'd0)) begin
         w_set_vec = 32'd1 << iss_rd;
      end else begin
         w_set_vec = 32'd0;
      end
      if (r_clr_vld) begin
         w_clr_vec = 32'd1 << r_clr_idx;
      end else begin
         w_clr_vec = 32'd0;
      end
      w_pending_nxt = ((r_pending & ~w_clr_vec) | w_set_vec) & ~32'd1;
   end

   // Scoreboard and deferred-clear registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= 32'd0;
         r_clr_vld <= 1'b0;
         r_clr_idx <= 5'd0;
      end else begin
         r_pending <= w_pending_nxt;
         r_clr_vld <= w_b_hs & (b_wr != 5'd0) & ~w_set_same;
         r_clr_idx <= b_wr;
      end
   end

   // Starvation counter: saturating, cleared on B acceptance or when B is idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (w_b_hs || !b_valid) begin
         r_starve_cnt <= 4'd0;
      end else if (!b_ready && (r_starve_cnt != 4'hF)) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
         r_starve_cnt <= r_starve_cnt;
      end
   end

   // RF write port register; x0 writes complete the handshake but never enable the RF
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rf_we <= 1'b0;
         r_rf_wr <= 5'd0;
         r_rf_wd <= 32'd0;
      end else if (w_b_hs) begin
         r_rf_we <= (b_wr != 5'd0);
         r_rf_wr <= b_wr;
         r_rf_wd <= b_wd;
      end else if (w_a_hs) begin
         r_rf_we <= (a_wr != 5'd0);
         r_rf_wr <= a_wr;
         r_rf_wd <= a_wd;
      end else begin
         r_rf_we <= 1'b0;
         r_rf_wr <= r_rf_wr;
         r_rf_wd <= r_rf_wd;
      end
   end

   assign hazard = r_pending[chk_r1] | r_pending[chk_r2];
   assign rf_we  = r_rf_we;
   assign rf_wR  = r_rf_wr;
   assign rf_wD  = r_rf_wd;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: directed vector table, starvation/reset
// sequences, then random traffic against a behavioural model.
module tb_rf_wport_arb;

   localparam int LIMIT = 4;

   logic        clk;
   logic        rst_n;
   logic        a_valid, b_valid, iss_valid;
   logic [4:0]  a_wr, b_wr, iss_rd, chk_r1, chk_r2;
   logic [31:0] a_wd, b_wd;
   logic        a_ready, b_ready, hazard, rf_we;
   logic [4:0]  rf_wR;
   logic [31:0] rf_wD;

   int n_checks;
   int n_fail;

   rf_wport_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_wr(a_wr), .a_wd(a_wd), .a_ready(a_ready),
      .b_valid(b_valid), .b_wr(b_wr), .b_wd(b_wd), .b_ready(b_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .chk_r1(chk_r1), .chk_r2(chk_r2), .hazard(hazard),
      .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model: pending set per register, each clear scheduled for a given edge
   int          m_starve;
   bit          m_pend [32];
   int          m_clr_at [32];
   bit          m_we;
   logic [4:0]  m_wr;
   logic [31:0] m_wd;
   int          m_edge;

   function automatic bit m_force();
      return (m_starve == LIMIT);
   endfunction

   function automatic bit m_ar();
      return m_force() ? !b_valid : 1'b1;
   endfunction

   function automatic bit m_br();
      return m_force() ? 1'b1 : !a_valid;
   endfunction

   function automatic bit m_hz();
      return m_pend[chk_r1] || m_pend[chk_r2];
   endfunction

   task automatic m_update();
      bit a_hs, b_hs, set_hit;
      a_hs = a_valid && m_ar();
      b_hs = b_valid && m_br();
      if (!rst_n) begin
         m_starve = 0;
         m_we = 1'b0;
         m_wr = 5'd0;
         m_wd = 32'd0;
         for (int r = 0; r < 32; r++) begin
            m_pend[r] = 1'b0;
            m_clr_at[r] = -1;
         end
      end else begin
         if (b_hs || !b_valid) m_starve = 0;
         else if (m_starve < 15) m_starve = m_starve + 1;
         if (b_hs) begin
            m_we = (b_wr != 0); m_wr = b_wr; m_wd = b_wd;
         end else if (a_hs) begin
            m_we = (a_wr != 0); m_wr = a_wr; m_wd = a_wd;
         end else begin
            m_we = 1'b0;
         end
         for (int r = 1; r < 32; r++) begin
            set_hit = iss_valid && (iss_rd == r);
            if (m_clr_at[r] == m_edge && !set_hit) m_pend[r] = 1'b0;
            if (m_clr_at[r] == m_edge) m_clr_at[r] = -1;
            if (set_hit) begin
               m_pend[r] = 1'b1;
               m_clr_at[r] = -1;
            end
            if (b_hs && b_wr == r && !set_hit) m_clr_at[r] = m_edge + 1;
         end
      end
      m_edge++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      m_update();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic rst; logic av; logic [4:0] awr; logic [31:0] awd;
      logic bv; logic [4:0] bwr; logic [31:0] bwd;
      logic iv; logic [4:0] ird; logic [4:0] c1; logic [4:0] c2;
      logic ear; logic ebr; logic ehz; logic ewe; logic [4:0] ewr; logic [31:0] ewd;
   } vec_t;

   vec_t tbl [17];
   bit   a_acc, b_acc;

   initial begin
      n_checks = 0; n_fail = 0; m_edge = 0;
      rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
      a_wr = 5'd0; b_wr = 5'd0; iss_rd = 5'd0; chk_r1 = 5'd0; chk_r2 = 5'd0;
      a_wd = 32'd0; b_wd = 32'd0;

      //          rst  av  awr   awd           bv  bwr   bwd              iv  ird   c1    c2     ar  br  hz  we  wr    wd
      tbl[0]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0};
      tbl[1]  = '{1'b1,1'b1,5'd5, 32'h1234,   1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd0,  1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0};
      tbl[2]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd0,  1'b1,1'b1,1'b0,1'b1,5'd5, 32'h1234};
      tbl[3]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b1,5'd9,5'd9, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd5, 32'h1234};
      tbl[4]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd9, 5'd0,  1'b1,1'b1,1'b1,1'b0,5'd5, 32'h1234};
      tbl[5]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b1,5'd9,32'hAAAA5555,   1'b0,5'd0,5'd9, 5'd0,  1'b1,1'b1,1'b1,1'b0,5'd5, 32'h1234};
      tbl[6]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd9, 5'd0,  1'b1,1'b1,1'b1,1'b1,5'd9, 32'hAAAA5555};
      tbl[7]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd9, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd9, 32'hAAAA5555};
      tbl[8]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b1,5'd0,32'hFFFFFFFF,   1'b1,5'd0,5'd0, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd9, 32'hAAAA5555};
      tbl[9]  = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd0,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'hFFFFFFFF};
      tbl[10] = '{1'b1,1'b0,5'd0, 32'h0,      1'b1,5'd3,32'h33,         1'b1,5'd3,5'd0, 5'd3,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'hFFFFFFFF};
      tbl[11] = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd3,  1'b1,1'b1,1'b1,1'b1,5'd3, 32'h33};
      tbl[12] = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd3,  1'b1,1'b1,1'b1,1'b0,5'd3, 32'h33};
      tbl[13] = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd3,  1'b1,1'b1,1'b1,1'b0,5'd3, 32'h33};
      tbl[14] = '{1'b1,1'b1,5'd12,32'h77,     1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd3,  1'b1,1'b0,1'b1,1'b0,5'd3, 32'h33};
      tbl[15] = '{1'b0,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd3,  1'b1,1'b1,1'b1,1'b1,5'd12,32'h77};
      tbl[16] = '{1'b1,1'b0,5'd0, 32'h0,      1'b0,5'd0,32'h0,          1'b0,5'd0,5'd0, 5'd3,  1'b1,1'b1,1'b0,1'b0,5'd0, 32'h0};

      tick();
      tick();

      for (int i = 0; i < 17; i++) begin
         rst_n = tbl[i].rst; a_valid = tbl[i].av; a_wr = tbl[i].awr; a_wd = tbl[i].awd;
         b_valid = tbl[i].bv; b_wr = tbl[i].bwr; b_wd = tbl[i].bwd;
         iss_valid = tbl[i].iv; iss_rd = tbl[i].ird; chk_r1 = tbl[i].c1; chk_r2 = tbl[i].c2;
         #2;
         chk($sformatf("vec%0d_a_ready", i), a_ready, tbl[i].ear);
         chk($sformatf("vec%0d_b_ready", i), b_ready, tbl[i].ebr);
         chk($sformatf("vec%0d_hazard", i), hazard, tbl[i].ehz);
         chk($sformatf("vec%0d_rf_we", i), rf_we, tbl[i].ewe);
         chk($sformatf("vec%0d_rf_wR", i), rf_wR, tbl[i].ewr);
         chk($sformatf("vec%0d_rf_wD", i), rf_wD, tbl[i].ewd);
         tick();
      end

      // starvation: A and B both held, B forced through on the fifth cycle
      rst_n = 1'b1; iss_valid = 1'b0; chk_r1 = 5'd0; chk_r2 = 5'd0;
      a_valid = 1'b1; b_valid = 1'b1; b_wr = 5'd7; b_wd = 32'hB7;
      for (int i = 0; i < 5; i++) begin
         a_wr = 5'(i + 1); a_wd = 32'(i);
         #2;
         chk($sformatf("starve%0d_a_ready", i), a_ready, 32'(i < 4));
         chk($sformatf("starve%0d_b_ready", i), b_ready, 32'(i == 4));
         tick();
      end
      b_valid = 1'b0;
      #2;
      chk("starve_commit_we", rf_we, 32'd1);
      chk("starve_commit_wR", rf_wR, 32'd7);
      chk("starve_commit_wD", rf_wD, 32'hB7);
      chk("starve_after_a_ready", a_ready, 32'd1);
      tick();

      // build up two blocked cycles, reset, then the full limit must elapse again
      a_wr = 5'd6; b_valid = 1'b1; b_wr = 5'd8; b_wd = 32'hB8;
      for (int i = 0; i < 3; i++) begin
         rst_n = (i == 2) ? 1'b0 : 1'b1;
         #2;
         chk($sformatf("prerst%0d_b_ready", i), b_ready, 32'd0);
         tick();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk($sformatf("postrst%0d_b_ready", i), b_ready, 32'(i == 4));
         if (i == 0) chk("postrst_rf_we", rf_we, 32'd0);
         tick();
      end
      b_valid = 1'b0; a_valid = 1'b0;
      #2;
      tick();

      // random traffic against the model
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!a_valid || a_acc) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_wr = 5'($urandom); a_wd = $urandom;
         end
         if (!b_valid || b_acc) begin
            b_valid = ($urandom_range(0, 1) != 0);
            b_wr = 5'($urandom); b_wd = $urandom;
         end
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_rd = 5'($urandom_range(0, 7));
         chk_r1 = 5'($urandom_range(0, 7));
         chk_r2 = 5'($urandom);
         #2;
         chk("rnd_a_ready", a_ready, m_ar());
         chk("rnd_b_ready", b_ready, m_br());
         chk("rnd_hazard", hazard, m_hz());
         chk("rnd_rf_we", rf_we, m_we);
         chk("rnd_rf_wR", rf_wR, m_wr);
         chk("rnd_rf_wD", rf_wD, m_wd);
         a_acc = a_valid && m_ar();
         b_acc = b_valid && m_br();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
